// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename-logic types and free-list sizing.
// Also holds the modular ring-index helper used by the free list.
package RenameLogicTypes;

    localparam int PREG_NUM     = 64;
    localparam int LREG_NUM     = 32;
    localparam int COMMIT_WIDTH = 2;
    localparam int RENAME_WIDTH = 2;

    localparam int PREG_W              = $clog2(PREG_NUM);
    localparam int FREE_LIST_ENTRY_NUM = PREG_NUM - LREG_NUM;
    localparam int FL_IDX_W            = $clog2(FREE_LIST_ENTRY_NUM);
    localparam int FL_CNT_W            = $clog2(FREE_LIST_ENTRY_NUM + 1);

    typedef logic [PREG_W-1:0]   PRegNumPath;
    typedef logic [FL_IDX_W-1:0] FreeListIndexPath;
    typedef logic [FL_CNT_W-1:0] FreeListCountPath;

    // Ring depth need not be a power of two, so wrap explicitly.
    function automatic FreeListIndexPath idx_add(
        input FreeListIndexPath base,
        input FreeListCountPath off
    );
        logic [FL_CNT_W:0] s;
        s = {1'b0, FreeListCountPath'(base)} + {1'b0, off};
        if (s >= (FL_CNT_W+1)'(FREE_LIST_ENTRY_NUM))
            s = s - (FL_CNT_W+1)'(FREE_LIST_ENTRY_NUM);
        return s[FL_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/phys_reg_free_list_compactor.sv
// Exclusive prefix count and total of a lane-valid vector.
// Turns sparse lanes into dense ring offsets.
module free_list_lane_compactor #(
    parameter int WIDTH = 2,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] valid_i,
    output logic [CW-1:0]    offset_o [WIDTH],
    output logic [CW-1:0]    total_o
);

    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            offset_o[i] = acc;
            acc = acc + CW'(valid_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers for the rename stage.
// Optional double-release detection: RSD_FREE_LIST_DUP_CHECK_EN.
module phys_reg_free_list
    import RenameLogicTypes::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COMMIT_WIDTH-1:0] releaseReg,
    input  PRegNumPath              phyReleasedReg [COMMIT_WIDTH],
    input  logic [RENAME_WIDTH-1:0] allocReq,
    output PRegNumPath              allocReg [RENAME_WIDTH],
    output logic                    allocReady,
    output FreeListCountPath        freeCount,
    output logic                    dupRelease
);

    localparam int DEPTH = FREE_LIST_ENTRY_NUM;
    localparam int REL_W = $clog2(COMMIT_WIDTH + 1);
    localparam int ALC_W = $clog2(RENAME_WIDTH + 1);

    PRegNumPath       entry_q [DEPTH];
    FreeListIndexPath head_q, head_d;
    FreeListIndexPath tail_q, tail_d;
    FreeListCountPath count_q, count_d;

    logic [COMMIT_WIDTH-1:0] relEff;
    logic [REL_W-1:0]        relOff [COMMIT_WIDTH];
    logic [REL_W-1:0]        relTotal;
    logic [ALC_W-1:0]        alcOff [RENAME_WIDTH];
    logic [ALC_W-1:0]        alcTotal;
    FreeListCountPath        popNum, pushNum;
    logic                    pushOk;

    free_list_lane_compactor #(.WIDTH(COMMIT_WIDTH)) u_rel_cmp (
        .valid_i  (relEff),
        .offset_o (relOff),
        .total_o  (relTotal)
    );

    free_list_lane_compactor #(.WIDTH(RENAME_WIDTH)) u_alc_cmp (
        .valid_i  (allocReq),
        .offset_o (alcOff),
        .total_o  (alcTotal)
    );

    assign allocReady = count_q >= FL_CNT_W'(RENAME_WIDTH);
    assign freeCount  = count_q;

    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++)
            allocReg[i] = entry_q[idx_add(head_q, FL_CNT_W'(alcOff[i]))];
    end

    // Pushes that would overrun the ring are dropped whole.
    always_comb begin
        logic [FL_CNT_W:0] sum;
        sum     = {1'b0, count_q} + (FL_CNT_W+1)'(relTotal);
        pushOk  = sum <= (FL_CNT_W+1)'(DEPTH);
        pushNum = pushOk ? FL_CNT_W'(relTotal) : '0;
        popNum  = allocReady ? FL_CNT_W'(alcTotal) : '0;
        head_d  = idx_add(head_q, popNum);
        tail_d  = idx_add(tail_q, pushNum);
        count_d = count_q - popNum + pushNum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                entry_q[k] <= PRegNumPath'(LREG_NUM + k);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FL_CNT_W'(DEPTH);
        end else begin
            for (int i = 0; i < COMMIT_WIDTH; i++)
                if (pushOk && relEff[i])
                    entry_q[idx_add(tail_q, FL_CNT_W'(relOff[i]))]
                        <= phyReleasedReg[i];
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef RSD_FREE_LIST_DUP_CHECK_EN
    logic [PREG_NUM-1:0] map_q, map_d, relSet;
    logic                dup_q, dup_d, dupHit;

    always_comb begin
        relEff = releaseReg;
        relSet = '0;
        dupHit = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (releaseReg[i]) begin
                if (map_q[phyReleasedReg[i]] || relSet[phyReleasedReg[i]]) begin
                    relEff[i] = 1'b0;
                    dupHit    = 1'b1;
                end else begin
                    relSet[phyReleasedReg[i]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        map_d = map_q;
        dup_d = dup_q | dupHit;
        if (allocReady)
            for (int i = 0; i < RENAME_WIDTH; i++)
                if (allocReq[i]) map_d[allocReg[i]] = 1'b0;
        if (pushOk) map_d = map_d | relSet;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PREG_NUM; p++)
                map_q[p] <= (p >= LREG_NUM);
            dup_q <= 1'b0;
        end else begin
            map_q <= map_d;
            dup_q <= dup_d;
        end
    end

    assign dupRelease = dup_q;
`else
    assign relEff     = releaseReg;
    assign dupRelease = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < COMMIT_WIDTH; i++)
                if (releaseReg[i])
                    assert (int'(phyReleasedReg[i]) < PREG_NUM);
            assert (int'(count_q) <= DEPTH);
            assert (!(int'(count_q) == DEPTH && relEff != '0));
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list.
// Dup-release steps run only with RSD_FREE_LIST_DUP_CHECK_EN.
module tb_phys_reg_free_list;
    import RenameLogicTypes::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [COMMIT_WIDTH-1:0] releaseReg;
    PRegNumPath              phyReleasedReg [COMMIT_WIDTH];
    logic [RENAME_WIDTH-1:0] allocReq;
    PRegNumPath              allocReg [RENAME_WIDTH];
    logic                    allocReady;
    FreeListCountPath        freeCount;
    logic                    dupRelease;

    int checks = 0;
    int errors = 0;

    phys_reg_free_list dut (
        .clk            (clk),
        .rst            (rst),
        .releaseReg     (releaseReg),
        .phyReleasedReg (phyReleasedReg),
        .allocReq       (allocReq),
        .allocReg       (allocReg),
        .allocReady     (allocReady),
        .freeCount      (freeCount),
        .dupRelease     (dupRelease)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        releaseReg = '0;
        allocReq   = '0;
    endtask

    task automatic rel(input logic [1:0] v, input int p0, input int p1);
        releaseReg        = v;
        phyReleasedReg[0] = PRegNumPath'(p0);
        phyReleasedReg[1] = PRegNumPath'(p1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rel(2'b00, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_count", freeCount, 32);
        chk("reset_ready", allocReady, 1);
        chk("reset_dup", dupRelease, 0);

        allocReq = 2'b11;
        #1;
        chk("t1_alloc0", allocReg[0], 32);
        chk("t1_alloc1", allocReg[1], 33);
        tick();
        idle();
        chk("t1_count", freeCount, 30);

        rel(2'b10, 7, 33);
        tick();
        idle();
        chk("t2_count", freeCount, 31);

        allocReq = 2'b10;
        #1;
        chk("sparse_alloc1", allocReg[1], 34);
        tick();
        idle();
        chk("sparse_count", freeCount, 30);

        for (int k = 0; k < 14; k++) begin
            allocReq = 2'b11;
            #1;
            chk("drain_a0", allocReg[0], 35 + 2 * k);
            chk("drain_a1", allocReg[1], 36 + 2 * k);
            tick();
        end
        idle();
        chk("drain_count", freeCount, 2);
        chk("drain_ready", allocReady, 1);

        allocReq = 2'b11;
        rel(2'b11, 5, 6);
        #1;
        chk("t5_alloc0", allocReg[0], 63);
        chk("t5_alloc1", allocReg[1], 33);
        tick();
        idle();
        chk("t5_count", freeCount, 2);
        allocReq = 2'b11;
        #1;
        chk("t5_next0", allocReg[0], 5);
        chk("t5_next1", allocReg[1], 6);
        tick();
        idle();
        chk("empty_count", freeCount, 0);
        chk("empty_ready", allocReady, 0);

        rel(2'b01, 9, 0);
        tick();
        idle();
        chk("t3_count1", freeCount, 1);
        chk("t3_notready", allocReady, 0);
        allocReq = 2'b11;
        tick();
        idle();
        chk("t3_stall_count", freeCount, 1);
        rel(2'b10, 0, 10);
        tick();
        idle();
        chk("t3_ready", allocReady, 1);
        chk("t3_count2", freeCount, 2);
        allocReq = 2'b11;
        #1;
        chk("t3_alloc0", allocReg[0], 9);
        chk("t3_alloc1", allocReg[1], 10);
        tick();
        idle();
        chk("t3_count0", freeCount, 0);

        for (int j = 0; j < 13; j++) begin
            rel(2'b11, 32 + 2 * j, 33 + 2 * j);
            tick();
        end
        idle();
        chk("t4_fill_count", freeCount, 26);
        rel(2'b11, 5, 6);
        tick();
        idle();
        chk("t4_wrap_count", freeCount, 28);
        for (int j = 0; j < 13; j++) begin
            allocReq = 2'b11;
            #1;
            chk("t4_pop0", allocReg[0], 32 + 2 * j);
            chk("t4_pop1", allocReg[1], 33 + 2 * j);
            tick();
        end
        allocReq = 2'b11;
        #1;
        chk("t4_wrap0", allocReg[0], 5);
        chk("t4_wrap1", allocReg[1], 6);
        tick();
        idle();
        chk("t4_count0", freeCount, 0);

        allocReq = 2'b11;
        rel(2'b11, 1, 2);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("rst2_count", freeCount, 32);
        chk("rst2_ready", allocReady, 1);
        allocReq = 2'b11;
        #1;
        chk("rst2_alloc0", allocReg[0], 32);
        chk("rst2_alloc1", allocReg[1], 33);
        tick();
        idle();
        chk("rst2_count30", freeCount, 30);

`ifdef RSD_FREE_LIST_DUP_CHECK_EN
        rel(2'b01, 35, 0);
        tick();
        idle();
        chk("t6_dup", dupRelease, 1);
        chk("t6_count", freeCount, 30);
        tick();
        chk("t6_sticky", dupRelease, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_clear", dupRelease, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
